fetch_predict_unit: RTL
=======================

# fetch_predict_unit

Fetch-stage PC generator and in-flight prediction tracker for the pipelined MIPS core. Each cycle it drives the fetch PC to instruction memory and the branch predictor read port, and picks the next PC from the predictor's taken/target answer. It records the prediction of every fetched instruction in an in-order queue. At EX resolution it compares each prediction against the actual outcome, redirects and flushes on mispredict, and issues the registered branch-predictor update.

## Interface
- DEPTH, 4: prediction queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  one clock; reset is asynchronous and active-high.
- ihit  in  1  instruction memory returned the word at `pc` this cycle.
- stall  in  1  decode hazard stall; hold fetch.
- pc  out  32  current fetch address, to imem and predictor read port.
- pred_taken  in  1  predictor says taken for `pc`; combinational from `pc`.
- pred_target  in  32  predicted target for `pc`.
- fetch_valid  out  1  instruction at `pc` accepted into pipeline this cycle.
- res_valid  in  1  EX retires the oldest in-flight instruction.
- res_is_branch  in  1  retired instruction is a branch/jump.
- res_taken  in  1  actual direction.
- res_target  in  32  actual target; meaningful only when `res_taken`.
- flush  out  1  one-cycle pulse; kill IF/ID/EX younger instructions.
- btb_wen  out  1  predictor update strobe.
- btb_wpc  out  32  PC of the resolved branch.
- btb_wtaken  out  1  actual direction.
- btb_wtarget  out  32  actual target.
- br_count  out  16  resolved branches; saturating.
- mp_count  out  16  mispredicts; saturating.
- q_err  out  1  sticky flag: `res_valid` seen while the queue was empty.

## Operation
- Queue entry holds {pc, pred_taken, pred_target}. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- fetch_valid = ihit & !stall & (count != DEPTH) & !mispredict.
- The full condition uses `count` only. A same-cycle pop does not free a slot for push.
- On fetch_valid:
  - Push the entry.
  - pc <= pred_taken ? pred_target : pc + 4. Addition is 32-bit and wraps.
- Resolution applies when res_valid & (count != 0). Compare against the queue head:
  - mispredict = (is_branch & (taken != head.pred_taken)) | (is_branch & taken & head.pred_taken & (target != head.pred_target)) | (!is_branch & head.pred_taken).
  - Correct target: taken ? res_target : head.pc + 4. Non-branch instructions use head.pc + 4.
  - On no mispredict: pop the head.
  - On mispredict:
    - Clear the queue: both pointers to 0, count to 0.
    - pc <= correct target.
    - flush = 1 for one cycle.
    - mp_count++.
    - Any same-cycle fetch push is discarded.
- Predictor update, when is_branch: next cycle btb_wen = 1 and {btb_wpc, btb_wtaken, btb_wtarget} = {head.pc, res_taken, res_target}. This happens whether or not the branch was mispredicted. br_count++ at the same time.
- Counters saturate at 16'hFFFF.
- res_valid with count == 0:
  - Sets q_err.
  - No pop, redirect or update.
  - q_err clears only on reset.
- Priority of PC update: mispredict redirect > fetch advance > hold.

## Timing
- Reset values: pc = RESET_PC, queue empty, flush = 0, btb_wen = 0, btb_wpc/btb_wtarget = 0, btb_wtaken = 0, counters = 0, q_err = 0.
- fetch_valid is combinational. The new pc is visible the cycle after acceptance.
- flush and the redirected pc are asserted the cycle after the resolving res_valid. The first fetch at the correct target can be accepted that same cycle.
- btb_wen and its data are registered, one cycle after resolution. btb_wen is a single-cycle pulse per resolved branch.
- Push and pop in the same cycle with no mispredict: count is unchanged and both pointers advance.
- RST asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset with RESET_PC = 0x100: pc = 0x100 and all outputs 0. Then 3 ihit cycles with pred_taken = 0: pc steps through 0x104, 0x108, 0x10C, and count = 3.
- Taken prediction at pc 0x200 with target 0x400, resolved taken to 0x400: pc goes to 0x400. No flush. Next cycle btb_wen = 1, btb_wpc = 0x200, btb_wtaken = 1, btb_wtarget = 0x400. br_count = 1.
- Predicted not-taken at 0x300, resolved taken to 0x500, with 2 younger entries queued: next cycle flush = 1, pc = 0x500, count = 0, mp_count = 1, btb_wen = 1.
- Non-branch at head with pred_taken = 1, head.pc 0x40: mispredict, pc = 0x44, flush = 1, btb_wen stays 0.
- DEPTH = 4 full with ihit held and a pop in the same cycle: fetch_valid = 0 that cycle and count goes to 3. Next cycle fetch_valid = 1.
- res_valid on an empty queue: q_err = 1, no flush, no btb_wen. Assert RST mid-run: q_err and both counters reset to 0 asynchronously.

Source files
------------

// File: rtl/fetch_predict_unit.sv
// Fetch PC generator with an in-order prediction queue; resolves predictions at EX,
// redirects/flushes on mispredict and issues the registered predictor update.
module fetch_predict_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        stall,
   output logic [31:0] pc,
   input  logic        pred_taken,
   input  logic [31:0] pred_target,
   output logic        fetch_valid,
   input  logic        res_valid,
   input  logic        res_is_branch,
   input  logic        res_taken,
   input  logic [31:0] res_target,
   output logic        flush,
   output logic        btb_wen,
   output logic [31:0] btb_wpc,
   output logic        btb_wtaken,
   output logic [31:0] btb_wtarget,
   output logic [15:0] br_count,
   output logic [15:0] mp_count,
   output logic        q_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   entry_t        q_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_q, pc_d;
   logic          flush_q, flush_d;
   logic          btb_wen_q, btb_wen_d;
   logic [31:0]   btb_wpc_q, btb_wpc_d;
   logic          btb_wtaken_q, btb_wtaken_d;
   logic [31:0]   btb_wtarget_q, btb_wtarget_d;
   logic [15:0]   br_count_q, br_count_d;
   logic [15:0]   mp_count_q, mp_count_d;
   logic          q_err_q, q_err_d;

   entry_t      head;
   logic        q_full, q_empty, res_fire, mispredict, push, pop, upd;
   logic [31:0] correct_pc;

   // Resolution against the queue head
   always_comb begin
      q_full     = (count_q == CW'(DEPTH));
      q_empty    = (count_q == '0);
      head       = q_mem[rd_ptr_q];
      res_fire   = res_valid & ~q_empty;
      mispredict = res_fire & (
                     (res_is_branch & (res_taken != head.taken)) |
                     (res_is_branch & res_taken & head.taken & (res_target != head.target)) |
                     (~res_is_branch & head.taken));
      correct_pc = (res_is_branch & res_taken) ? res_target : head.pc + 32'd4;
      upd        = res_fire & res_is_branch;
      push       = ihit & ~stall & ~q_full & ~mispredict;
      pop        = res_fire & ~mispredict;
   end

   assign fetch_valid = push;

   always_comb begin
      pc_d          = pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      flush_d       = mispredict;
      btb_wen_d     = upd;
      btb_wpc_d     = btb_wpc_q;
      btb_wtaken_d  = btb_wtaken_q;
      btb_wtarget_d = btb_wtarget_q;
      br_count_d    = br_count_q;
      mp_count_d    = mp_count_q;
      q_err_d       = q_err_q | (res_valid & q_empty);

      if (mispredict) begin
         pc_d     = correct_pc;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_d     = pred_taken ? pred_target : pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end

      if (upd) begin
         btb_wpc_d     = head.pc;
         btb_wtaken_d  = res_taken;
         btb_wtarget_d = res_target;
         if (br_count_q != 16'hFFFF) br_count_d = br_count_q + 16'd1;
      end
      if (mispredict && mp_count_q != 16'hFFFF) mp_count_d = mp_count_q + 16'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q          <= RESET_PC;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         flush_q       <= 1'b0;
         btb_wen_q     <= 1'b0;
         btb_wpc_q     <= '0;
         btb_wtaken_q  <= 1'b0;
         btb_wtarget_q <= '0;
         br_count_q    <= '0;
         mp_count_q    <= '0;
         q_err_q       <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         flush_q       <= flush_d;
         btb_wen_q     <= btb_wen_d;
         btb_wpc_q     <= btb_wpc_d;
         btb_wtaken_q  <= btb_wtaken_d;
         btb_wtarget_q <= btb_wtarget_d;
         br_count_q    <= br_count_d;
         mp_count_q    <= mp_count_d;
         q_err_q       <= q_err_d;
      end
   end

   // Entry storage is only read when count says it holds valid data
   always_ff @(posedge CLK) begin
      if (push) q_mem[wr_ptr_q] <= '{pc: pc_q, taken: pred_taken, target: pred_target};
   end

   assign pc          = pc_q;
   assign flush       = flush_q;
   assign btb_wen     = btb_wen_q;
   assign btb_wpc     = btb_wpc_q;
   assign btb_wtaken  = btb_wtaken_q;
   assign btb_wtarget = btb_wtarget_q;
   assign br_count    = br_count_q;
   assign mp_count    = mp_count_q;
   assign q_err       = q_err_q;

endmodule
